// File: rtl/ema_engine.sv
// ema_engine: per-channel exponential moving average over integer prices, 3-stage pipeline.
// Define EMA_DEVIATION_EN to add out_dev = |sample - previous ema| alongside each result.
module ema_engine #(
  parameter int unsigned         NUM_CH      = 8,
  parameter int unsigned         PRICE_BITS  = 48,
  parameter int unsigned         FRAC_W      = 16,
  parameter int unsigned         ALPHA_W     = 16,
  parameter logic [ALPHA_W-1:0]  ALPHA_RESET = 16'h0800,
  localparam int unsigned        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned        Q_W         = PRICE_BITS + FRAC_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [PRICE_BITS-1:0] in_price,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [ALPHA_W-1:0]    cfg_alpha,
  input  logic                  clr_valid,
  input  logic [CH_W-1:0]       clr_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_W-1:0]       out_ch,
  output logic [Q_W-1:0]        out_ema,
`ifdef EMA_DEVIATION_EN
  output logic [Q_W-1:0]        out_dev,
`endif
  output logic                  out_first
);

  localparam logic [ALPHA_W-1:0] ALPHA_ONE = ALPHA_W'(1) << (ALPHA_W - 1);
  localparam int unsigned        P_W       = Q_W + ALPHA_W + 2;

  function automatic logic ch_ok(input logic [CH_W-1:0] c);
    return 32'(c) < NUM_CH;
  endfunction

  logic [Q_W-1:0]     ema_q   [NUM_CH];
  logic [ALPHA_W-1:0] alpha_q [NUM_CH];
  logic [NUM_CH-1:0]  seeded_q;

  logic               s1_v_q, s1_seeded_q;
  logic [CH_W-1:0]    s1_ch_q;
  logic [Q_W-1:0]     s1_px_q, s1_ema_q;
  logic [ALPHA_W-1:0] s1_alpha_q;

  logic               s2_v_q, s2_first_q;
  logic [CH_W-1:0]    s2_ch_q;
  logic [Q_W-1:0]     s2_base_q, s2_inc_q;

  logic               out_valid_q, out_first_q;
  logic [CH_W-1:0]    out_ch_q;
  logic [Q_W-1:0]     out_ema_q;

  logic               adv, hazard, accept, in_ok;
  logic [Q_W-1:0]     rd_ema, ema_new, inc;
  logic               rd_seeded;
  logic [ALPHA_W-1:0] rd_alpha;
  logic signed [Q_W:0]   diff;
  logic signed [P_W-1:0] prod;

  // S0: the accepting cycle reads channel state; S1/S2 hold the only in-flight readers.
  always_comb begin
    adv       = !(out_valid_q && !out_ready);
    hazard    = (s1_v_q && (s1_ch_q == in_ch)) || (s2_v_q && (s2_ch_q == in_ch));
    in_ready  = rst_n && adv && !hazard;
    accept    = in_valid && in_ready;
    in_ok     = ch_ok(in_ch);
    rd_ema    = '0;
    rd_seeded = 1'b0;
    rd_alpha  = '0;
    if (in_ok) begin
      rd_ema    = ema_q[in_ch];
      rd_seeded = seeded_q[in_ch];
      rd_alpha  = (alpha_q[in_ch] > ALPHA_ONE) ? ALPHA_ONE : alpha_q[in_ch];
    end
  end

  always_comb begin
    diff    = $signed({1'b0, s1_px_q}) - $signed({1'b0, s1_ema_q});
    prod    = P_W'(diff) * P_W'($signed({1'b0, s1_alpha_q}));
    inc     = Q_W'(prod >>> (ALPHA_W - 1));
    // Modular add is exact: the true result always lies between old ema and sample.
    ema_new = s2_base_q + s2_inc_q;
  end

`ifdef EMA_DEVIATION_EN
  logic [Q_W-1:0] dev, s2_dev_q, out_dev_q;
  always_comb dev = diff[Q_W] ? Q_W'(-diff) : Q_W'(diff);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_dev_q  <= '0;
      out_dev_q <= '0;
    end else if (adv) begin
      s2_dev_q <= s1_seeded_q ? dev : '0;
      if (s2_v_q) out_dev_q <= s2_dev_q;
    end
  end
  assign out_dev = out_dev_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_seeded_q <= 1'b0;
      s1_ch_q     <= '0;
      s1_px_q     <= '0;
      s1_ema_q    <= '0;
      s1_alpha_q  <= '0;
      s2_v_q      <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_ch_q     <= '0;
      s2_base_q   <= '0;
      s2_inc_q    <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_ch_q    <= '0;
      out_ema_q   <= '0;
    end else if (adv) begin
      s1_v_q <= accept && in_ok;
      if (accept) begin
        s1_seeded_q <= rd_seeded;
        s1_ch_q     <= in_ch;
        s1_px_q     <= {in_price, {FRAC_W{1'b0}}};
        s1_ema_q    <= rd_ema;
        s1_alpha_q  <= rd_alpha;
      end
      s2_v_q     <= s1_v_q;
      s2_first_q <= !s1_seeded_q;
      s2_ch_q    <= s1_ch_q;
      s2_base_q  <= s1_seeded_q ? s1_ema_q : s1_px_q;
      s2_inc_q   <= s1_seeded_q ? inc : '0;
      out_valid_q <= s2_v_q;
      if (s2_v_q) begin
        out_ch_q    <= s2_ch_q;
        out_ema_q   <= ema_new;
        out_first_q <= s2_first_q;
      end
    end
  end

  // Clear is applied after writeback so it wins on a same-edge collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seeded_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ema_q[i]   <= '0;
        alpha_q[i] <= ALPHA_RESET;
      end
    end else begin
      if (adv && s2_v_q) begin
        ema_q[s2_ch_q]    <= ema_new;
        seeded_q[s2_ch_q] <= 1'b1;
      end
      if (clr_valid && ch_ok(clr_ch)) seeded_q[clr_ch] <= 1'b0;
      if (cfg_we && ch_ok(cfg_ch)) alpha_q[cfg_ch] <= cfg_alpha;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_ema   = out_ema_q;
  assign out_first = out_first_q;

endmodule

// File: tb/tb_ema_engine.sv
// Scoreboard bench for ema_engine with 6 channels so that channel codes 6/7 are out of range.
module tb_ema_engine;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_ch;
  logic [47:0] in_price;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_alpha;
  logic        clr_valid;
  logic [2:0]  clr_ch;
  logic        out_valid, out_ready, out_first;
  logic [2:0]  out_ch;
  logic [63:0] out_ema;
`ifdef EMA_DEVIATION_EN
  logic [63:0] out_dev;
`endif

  ema_engine #(.NUM_CH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_price(in_price),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_alpha(cfg_alpha),
    .clr_valid(clr_valid), .clr_ch(clr_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_ema(out_ema),
`ifdef EMA_DEVIATION_EN
    .out_dev(out_dev),
`endif
    .out_first(out_first)
  );

  typedef struct { logic [2:0] ch; logic [63:0] ema; logic first; } exp_t;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   stalls = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got ch=%0d ema=%h first=%0b, none expected", out_ch, out_ema, out_first);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_ch !== e.ch || out_ema !== e.ema || out_first !== e.first) begin
          n_err++;
          $display("FAIL result: got ch=%0d ema=%h first=%0b, expected ch=%0d ema=%h first=%0b",
                   out_ch, out_ema, out_first, e.ch, e.ema, e.first);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int ch, input longint unsigned price, input bit push,
                      input logic [63:0] ema, input bit first);
    int unsigned waited = 0;
    in_valid = 1'b1;
    in_ch    = 3'(ch);
    in_price = 48'(price);
    #1;
    while (!in_ready) begin
      stalls++;
      waited++;
      if (waited > 20) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: ch=%0d never accepted, expected acceptance within 20 cycles", ch);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    if (push) sb.push_back('{ch: 3'(ch), ema: ema, first: first});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic cfg(input int ch, input logic [15:0] a);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_alpha = a;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clr(input int ch);
    clr_valid = 1'b1; clr_ch = 3'(ch);
    @(negedge clk);
    clr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_price = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_alpha = '0;
    clr_valid = 1'b0; clr_ch = '0; out_ready = 1'b1;
    idle(3);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_ema", out_ema, 64'd0);
    chk("rst_out_ch_first", {out_ch, out_first}, 64'd0);
    rst_n = 1'b1;
    idle(1);

    // seeding and latency
    send(0, 100, 1, 64'h64_0000, 1);
    chk("lat_edge1", 64'(out_valid), 64'd0);
    idle(1);
    chk("lat_edge2", 64'(out_valid), 64'd0);
    idle(1);
    chk("lat_edge3", 64'(out_valid), 64'd1);
    idle(2);

    // same-channel hazard: second sample waits two cycles
    stalls = 0;
    send(0, 116, 1, 64'h65_0000, 0);
    send(0, 132, 1, 64'h66_F000, 0);
    chk("hazard_stalls", 64'(stalls), 64'd2);
    idle(4);

    // distinct channels stream without stalls
    stalls = 0;
    send(0, 148, 1, 64'h69_C100, 0);
    send(1, 200, 1, 64'hC8_0000, 1);
    send(2, 7,   1, 64'h07_0000, 1);
    chk("distinct_stalls", 64'(stalls), 64'd0);
    idle(4);

    // backpressure with three in flight
    out_ready = 1'b0;
    cfg(3, 16'h8000);
    send(1, 216, 1, 64'hC9_0000, 0);
    send(2, 23,  1, 64'h08_0000, 0);
    send(3, 50,  1, 64'h32_0000, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", {out_ch, out_first, out_ema[59:0]}, {3'd1, 1'b0, 60'hC9_0000});
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      idle(1);
    end
    out_ready = 1'b1;
    idle(5);

    // alpha = 1.0, clamped alpha, then clear/reseed
    send(3, 80, 1, 64'h50_0000, 0);
    cfg(2, 16'hFFFF);
    send(2, 40, 1, 64'h28_0000, 0);
    idle(4);
    clr(3);
    send(3, 10, 1, 64'h0A_0000, 1);
    idle(4);

    // cfg on the accepting edge uses the old alpha; the next sample sees the new one
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_alpha = 16'h8000;
    send(1, 232, 1, 64'hCA_F000, 0);
    cfg_we = 1'b0;
    send(1, 300, 1, 64'h12C_0000, 0);
    idle(4);

    // out-of-range channels are accepted and dropped
    stalls = 0;
    send(6, 999, 0, '0, 0);
    send(7, 999, 0, '0, 0);
    chk("oob_stalls", 64'(stalls), 64'd0);
    idle(5);

    // reset with two in flight
    send(0, 1, 0, '0, 0);
    send(1, 2, 0, '0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    idle(2);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rel_no_valid", 64'(out_valid), 64'd0);
    end
    send(0, 5,  1, 64'h05_0000, 1);
    send(1, 10, 1, 64'h0A_0000, 1);
    send(1, 26, 1, 64'h0B_0000, 0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
